hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard unit.
- Replaces the single-cycle load-use check with a per-register latency scoreboard, so producers of any result latency (ALU 0, load 1, multiply/divide N) stall dependent consumers in ID for exactly the required cycles.
- Replaces the single-cycle branch squash with a programmable multi-cycle flush window.
- Sits beside the IF/ID and ID/EX pipeline registers; drives their stall and flush controls.

---
 rtl/hazard_scoreboard_pkg.sv | 18 +
 rtl/hazard_scoreboard_flush_timer.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard and its flush timer.
// Widths here are the defaults; the modules stay parametrised on top of them.
package hazard_scoreboard_pkg;

  localparam int DEF_REG_NUM_W = 5;
  localparam int DEF_LAT_W     = 3;

  typedef logic [DEF_REG_NUM_W-1:0] reg_num_path_t;
  typedef logic [DEF_LAT_W-1:0]     lat_path_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Result latencies of the two classic producer classes.
  localparam lat_path_t LAT_ALU  = lat_path_t'(0);
  localparam lat_path_t LAT_LOAD = lat_path_t'(1);

endpackage

// File: rtl/hazard_scoreboard_flush_timer.sv
// Branch flush window: a taken branch holds c_hazard high for FLUSH_DEPTH
// cycles; a new taken branch restarts the window instead of extending it.
module hazard_flush_timer
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W       = DEF_LAT_W,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic br_taken,
  output logic c_hazard
);

  logic [LAT_W-1:0] flush_cnt_q;
  logic [LAT_W-1:0] flush_cnt_d;
  logic             c_hazard_q;
  logic             c_hazard_d;

  always_comb begin
    flush_cnt_d = '0;
    c_hazard_d  = FALSE;
    if (br_taken) begin
      flush_cnt_d = LAT_W'(FLUSH_DEPTH);
      c_hazard_d  = TRUE;
    end else if (flush_cnt_q > LAT_W'(1)) begin
      flush_cnt_d = flush_cnt_q - LAT_W'(1);
      c_hazard_d  = TRUE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      c_hazard_q  <= FALSE;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      c_hazard_q  <= c_hazard_d;
    end
  end

  assign c_hazard = c_hazard_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: stalls ID consumers until every producer
// result they read is forwardable, and drives the branch flush controls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_NUM_W   = DEF_REG_NUM_W,
  parameter int LAT_W       = DEF_LAT_W,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_NUM_W-1:0] ifidRS,
  input  logic [REG_NUM_W-1:0] ifidRT,
  input  logic                 ifidUsesRS,
  input  logic                 ifidUsesRT,
  input  logic                 issueValid,
  input  logic                 issueWritesReg,
  input  logic [REG_NUM_W-1:0] issueDst,
  input  logic [LAT_W-1:0]     issueLat,
  input  logic                 brTaken,
  output logic                 dHazard,
  output logic                 cHazard,
  output logic                 pendingAny
);

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                rs_busy;
  logic                rt_busy;
  logic                accept;
  logic                pending_d;
  logic                pending_q;
  logic                c_hazard;

  hazard_flush_timer #(
    .LAT_W      (LAT_W),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) u_flush_timer (
    .clk     (clk),
    .rst     (rst),
    .br_taken(brTaken),
    .c_hazard(c_hazard)
  );

  // Register 0 is never tracked, so its busy bit stays at the default 0.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = |cnt_q[r];
    end
  end

  always_comb begin
    rs_busy = FALSE;
    rt_busy = FALSE;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (ifidRS == REG_NUM_W'(r)) rs_busy = busy[r];
      if (ifidRT == REG_NUM_W'(r)) rt_busy = busy[r];
    end
  end

  assign dHazard = !c_hazard && issueValid &&
                   ((ifidUsesRS && rs_busy) || (ifidUsesRT && rt_busy));

  // Anything issued alongside a taken branch is younger than it and is squashed.
  assign accept = issueValid && !dHazard && !c_hazard && !brTaken &&
                  issueWritesReg && (issueDst != '0) &&
                  (issueLat != LAT_W'(LAT_ALU));

  always_comb begin
    pending_d = FALSE;
    cnt_d[0]  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (accept && (issueDst == REG_NUM_W'(r))) begin
        cnt_d[r] = issueLat;
      end else if (busy[r]) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end else begin
        cnt_d[r] = '0;
      end
      pending_d = pending_d | (|cnt_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      pending_q <= FALSE;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_q <= pending_d;
    end
  end

  assign cHazard    = c_hazard;
  assign pendingAny = pending_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed output
// expectations into a queue; a monitor pops and compares them at each probe.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ifidRS = '0;
  logic [4:0] ifidRT = '0;
  logic       ifidUsesRS = 1'b0;
  logic       ifidUsesRT = 1'b0;
  logic       issueValid = 1'b0;
  logic       issueWritesReg = 1'b0;
  logic [4:0] issueDst = '0;
  logic [2:0] issueLat = '0;
  logic       brTaken = 1'b0;
  logic       dHazard;
  logic       cHazard;
  logic       pendingAny;

  typedef struct {
    string nm;
    logic  d;
    logic  c;
    logic  p;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  event probe_ev;

  hazard_scoreboard #(
    .NUM_REGS(32), .REG_NUM_W(5), .LAT_W(3), .FLUSH_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ifidRS(ifidRS), .ifidRT(ifidRT),
    .ifidUsesRS(ifidUsesRS), .ifidUsesRT(ifidUsesRT),
    .issueValid(issueValid), .issueWritesReg(issueWritesReg),
    .issueDst(issueDst), .issueLat(issueLat),
    .brTaken(brTaken),
    .dHazard(dHazard), .cHazard(cHazard), .pendingAny(pendingAny)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: outputs are sampled on the falling edge, or on an explicit probe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or probe_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (dHazard !== e.d) begin
          errors++;
          $display("FAIL %s dHazard: got %b want %b", e.nm, dHazard, e.d);
        end
        if (cHazard !== e.c) begin
          errors++;
          $display("FAIL %s cHazard: got %b want %b", e.nm, cHazard, e.c);
        end
        if (pendingAny !== e.p) begin
          errors++;
          $display("FAIL %s pendingAny: got %b want %b", e.nm, pendingAny, e.p);
        end
      end
    end
  end

  task automatic push(input string nm, input logic d, input logic c, input logic p);
    exp_t e;
    e.nm = nm; e.d = d; e.c = c; e.p = p;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs, queue the expected outputs for this cycle, advance.
  task automatic cyc(input string nm, input logic v,
                     input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic wr, input logic [4:0] dst, input logic [2:0] lat,
                     input logic br, input logic ed, input logic ec, input logic ep);
    issueValid = v; ifidRS = rs; ifidUsesRS = urs; ifidRT = rt; ifidUsesRT = urt;
    issueWritesReg = wr; issueDst = dst; issueLat = lat; brTaken = br;
    push(nm, ed, ec, ep);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic ec, input logic ep);
    cyc(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, ec, ep);
  endtask

  task automatic issue(input string nm, input logic [4:0] dst, input logic [2:0] lat,
                       input logic ec, input logic ep);
    cyc(nm, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, dst, lat, 1'b0, 1'b0, ec, ep);
  endtask

  task automatic use_rs(input string nm, input logic [4:0] rs,
                        input logic ed, input logic ec, input logic ep);
    cyc(nm, 1'b1, rs, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, ed, ec, ep);
  endtask

  task automatic use_rt(input string nm, input logic [4:0] rt,
                        input logic ed, input logic ec, input logic ep);
    cyc(nm, 1'b1, 5'd0, 1'b0, rt, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, ed, ec, ep);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      issueValid = 1'($urandom); ifidRS = 5'($urandom); ifidRT = 5'($urandom);
      ifidUsesRS = 1'($urandom); ifidUsesRT = 1'($urandom);
      issueWritesReg = 1'($urandom); issueDst = 5'($urandom);
      issueLat = 3'($urandom); brTaken = 1'($urandom);
      push("reset_hold", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    for (int r = 1; r < 32; r++) use_rs("post_reset_clear", 5'(r), 1'b0, 1'b0, 1'b0);

    // Load-use: one bubble.
    issue ("load_issue",  5'd5, 3'd1, 1'b0, 1'b0);
    use_rs("load_use_stall", 5'd5, 1'b1, 1'b0, 1'b1);
    use_rs("load_use_go",    5'd5, 1'b0, 1'b0, 1'b0);
    issue ("load_issue2", 5'd5, 3'd1, 1'b0, 1'b0);
    cyc   ("load_no_use", 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0,
           1'b0, 1'b0, 1'b1);
    idle  ("load_drained", 1'b0, 1'b0);

    // Latency-4 producer: four stall cycles on RT.
    issue ("mul_issue", 5'd7, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) use_rt("mul_stall", 5'd7, 1'b1, 1'b0, 1'b1);
    use_rt("mul_go", 5'd7, 1'b0, 1'b0, 1'b0);

    // WAW: newer shorter latency overrides.
    issue ("waw_first",  5'd7, 3'd4, 1'b0, 1'b0);
    issue ("waw_second", 5'd7, 3'd1, 1'b0, 1'b1);
    use_rt("waw_stall",  5'd7, 1'b1, 1'b0, 1'b1);
    use_rt("waw_go",     5'd7, 1'b0, 1'b0, 1'b0);

    // Register zero and ALU latency are never tracked.
    issue ("r0_issue", 5'd0, 3'd3, 1'b0, 1'b0);
    use_rs("r0_use",   5'd0, 1'b0, 1'b0, 1'b0);
    issue ("alu_issue", 5'd8, 3'd0, 1'b0, 1'b0);
    use_rs("alu_use",   5'd8, 1'b0, 1'b0, 1'b0);

    // Max latency on the top register, both sources, invalid ID first.
    issue ("max_issue", 5'd31, 3'd7, 1'b0, 1'b0);
    cyc   ("max_invalid", 1'b0, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0,
           1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cyc("max_stall", 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0,
          1'b1, 1'b0, 1'b1);
    cyc   ("max_go", 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0,
           1'b0, 1'b0, 1'b0);

    // Branch with a simultaneous issue: window of 2, issue dropped.
    cyc   ("br_with_issue", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 3'd2, 1'b1,
           1'b0, 1'b0, 1'b0);
    use_rs("flush_1", 5'd4, 1'b0, 1'b1, 1'b0);
    idle  ("flush_2", 1'b1, 1'b0);
    use_rs("flush_end_r4_clear", 5'd4, 1'b0, 1'b0, 1'b0);

    // Back-to-back branches restart the window.
    cyc("br_a", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("br_b", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("restart_1", 1'b1, 1'b0);
    idle("restart_2", 1'b1, 1'b0);
    idle("restart_end", 1'b0, 1'b0);

    // Pending stall masked by flush; counter keeps decrementing underneath.
    issue("mask_issue", 5'd6, 3'd4, 1'b0, 1'b0);
    cyc  ("mask_br_stall", 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1,
          1'b1, 1'b0, 1'b1);
    use_rs("mask_1", 5'd6, 1'b0, 1'b1, 1'b1);
    use_rs("mask_2", 5'd6, 1'b0, 1'b1, 1'b1);
    use_rs("mask_after", 5'd6, 1'b1, 1'b0, 1'b1);
    use_rs("mask_go",    5'd6, 1'b0, 1'b0, 1'b0);

    // Async reset with r9 busy and a flush in progress.
    issue("ar_issue", 5'd9, 3'd4, 1'b0, 1'b0);
    cyc  ("ar_br", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1,
          1'b0, 1'b0, 1'b1);
    issueValid = 1'b1; ifidRS = 5'd9; ifidUsesRS = 1'b1; issueWritesReg = 1'b0;
    brTaken = 1'b0;
    push("ar_before", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push("ar_immediate", 1'b0, 1'b0, 1'b0);
    ->probe_ev;
    @(posedge clk);
    #1;
    use_rs("ar_held", 5'd9, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    use_rs("ar_released_1", 5'd9, 1'b0, 1'b0, 1'b0);
    use_rs("ar_released_2", 5'd9, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
